// File: rtl/param_shift_harness.sv
// rtl/param_shift_harness.sv - multi-channel serial-to-parallel shifter with result serialiser
//
// Purpose:
//   NCH serial channels each shift into a WIDTH-bit register. The registers are
//   exposed in parallel to a downstream datapath. Once every channel holds a
//   full window, a captured OUTW-bit result word is returned LSB first on a
//   single serial line by a two-state output FSM.
//
// Ports:
//   clk          - single clock, all state on its rising edge
//   rst_n        - synchronous active-low reset, highest priority
//   shift_en     - shift every channel by one bit this cycle
//   clear        - zero channel registers and fill counter (FSM untouched)
//   src_ser      - serial input bit per channel, bit k feeds channel k
//   par_out      - channel k register at [k*WIDTH +: WIDTH], straight from flops
//   window_valid - every channel holds WIDTH bits shifted since reset/clear
//   res_in       - result word from the downstream datapath
//   capture      - request to sample res_in and serialise it
//   res_ser      - serial result bit, LSB first
//   res_valid    - res_ser carries a valid bit
//   res_done     - one-cycle pulse in the first idle cycle after the last bit
//   overrun      - sticky flag for a rejected capture, cleared only by reset

module param_shift_harness #(
    parameter int NCH   = 32,
    parameter int WIDTH = 32,
    parameter int OUTW  = 38
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   shift_en,
    input  logic                   clear,
    input  logic [NCH-1:0]         src_ser,
    output logic [NCH*WIDTH-1:0]   par_out,
    output logic                   window_valid,
    input  logic [OUTW-1:0]        res_in,
    input  logic                   capture,
    output logic                   res_ser,
    output logic                   res_valid,
    output logic                   res_done,
    output logic                   overrun
);

    localparam int FW = $clog2(WIDTH + 1);
    localparam int IW = $clog2(OUTW);
    localparam logic [FW-1:0] FILL_FULL = FW'(WIDTH);
    localparam logic [IW-1:0] IDX_LAST  = IW'(OUTW - 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_SEND = 1'b1
    } state_t;

    logic [NCH*WIDTH-1:0] r_chan;
    logic [FW-1:0]        r_fill;
    logic                 r_wv;

    state_t               r_state;
    logic [OUTW-1:0]      r_outreg;
    logic [IW-1:0]        r_idx;
    logic                 r_ser;
    logic                 r_valid;
    logic                 r_done;
    logic                 r_ovr;

    logic [FW-1:0]        w_fill_nxt;
    logic [IW-1:0]        w_idx_nxt;

    // Fill counter saturates so window_valid stays high under continuous shifting.
    assign w_fill_nxt = (r_fill == FILL_FULL) ? r_fill : r_fill + 1'b1;
    assign w_idx_nxt  = r_idx + 1'b1;

    // Channel shift registers and fill tracking.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_chan <= '0;
            r_fill <= '0;
            r_wv   <= 1'b0;
        end else if (clear) begin
            r_chan <= '0;
            r_fill <= '0;
            r_wv   <= 1'b0;
        end else if (shift_en) begin
            for (int k = 0; k < NCH; k++) begin
                r_chan[k*WIDTH +: WIDTH] <= {r_chan[k*WIDTH +: WIDTH-1], src_ser[k]};
            end
            r_fill <= w_fill_nxt;
            r_wv   <= (w_fill_nxt == FILL_FULL);
        end
    end

    // Output FSM. res_ser is preloaded with the next bit so every output is a flop.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_outreg <= '0;
            r_idx    <= '0;
            r_ser    <= 1'b0;
            r_valid  <= 1'b0;
            r_done   <= 1'b0;
            r_ovr    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (capture) begin
                        if (r_wv) begin
                            r_outreg <= res_in;
                            r_idx    <= '0;
                            r_ser    <= res_in[0];
                            r_valid  <= 1'b1;
                            r_state  <= S_SEND;
                        end else begin
                            r_ovr <= 1'b1;
                        end
                    end
                end
                S_SEND: begin
                    if (capture) begin
                        r_ovr <= 1'b1;
                    end
                    if (r_idx == IDX_LAST) begin
                        r_state <= S_IDLE;
                        r_valid <= 1'b0;
                        r_ser   <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_idx <= w_idx_nxt;
                        r_ser <= r_outreg[w_idx_nxt];
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign par_out      = r_chan;
    assign window_valid = r_wv;
    assign res_ser      = r_ser;
    assign res_valid    = r_valid;
    assign res_done     = r_done;
    assign overrun      = r_ovr;

endmodule

// File: tb/tb_param_shift_harness.sv
// tb/tb_param_shift_harness.sv - self-checking bench for param_shift_harness
module tb_param_shift_harness;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          shift_en, clear, capture;
    logic [31:0]   src_ser;
    logic [37:0]   res_in;
    logic [1023:0] par_out;
    logic          window_valid, res_ser, res_valid, res_done, overrun;

    logic          b_shift_en, b_clear, b_capture;
    logic [3:0]    b_src;
    logic [4:0]    b_res_in;
    logic [31:0]   b_par_out;
    logic          b_wv, b_res_ser, b_res_valid, b_res_done, b_overrun;

    param_shift_harness dut_a (
        .clk(clk), .rst_n(rst_n), .shift_en(shift_en), .clear(clear),
        .src_ser(src_ser), .par_out(par_out), .window_valid(window_valid),
        .res_in(res_in), .capture(capture), .res_ser(res_ser),
        .res_valid(res_valid), .res_done(res_done), .overrun(overrun)
    );

    param_shift_harness #(.NCH(4), .WIDTH(8), .OUTW(5)) dut_b (
        .clk(clk), .rst_n(rst_n), .shift_en(b_shift_en), .clear(b_clear),
        .src_ser(b_src), .par_out(b_par_out), .window_valid(b_wv),
        .res_in(b_res_in), .capture(b_capture), .res_ser(b_res_ser),
        .res_valid(b_res_valid), .res_done(b_res_done), .overrun(b_overrun)
    );

    typedef struct {
        logic sh;
        logic b;
        logic exp_wv;
    } fill_vec_t;

    typedef struct {
        logic [3:0] src;
        logic       exp_wv;
    } bvec_t;

    fill_vec_t tbl[32];
    bvec_t     btbl[10];

    int checks = 0;
    int errors = 0;
    bit sb_a[$];
    bit sb_b[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] e);
        checks++;
        if (act !== e) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, e);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_a(input logic [37:0] w);
        for (int i = 0; i < 38; i++) sb_a.push_back(w[i]);
    endtask

    task automatic fill_a(input int n);
        shift_en = 1'b1;
        for (int i = 0; i < n; i++) begin
            src_ser = $urandom;
            step();
        end
        shift_en = 1'b0;
    endtask

    // Samples the serial output each cycle and compares against the scoreboard.
    task automatic collect_a(input int budget, input int clear_at, input int cap_at,
                             output int nv, output int nd, output int dat);
        bit e;
        nv = 0; nd = 0; dat = -1;
        for (int i = 0; i < budget; i++) begin
            if (res_valid) begin
                nv++;
                if (sb_a.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL res_ser_unexpected: got valid bit %0b expected no bit", res_ser);
                end else begin
                    e = sb_a.pop_front();
                    check("res_ser", res_ser, e);
                end
            end
            if (res_done) begin
                nd++;
                dat = i;
            end
            clear   = (i == clear_at);
            capture = (i == cap_at);
            if (i == cap_at) res_in = 38'h3F_FFFF_FFFF;
            step();
        end
        clear   = 1'b0;
        capture = 1'b0;
    endtask

    logic [31:0] m_bpar;
    logic [4:0]  b_word;
    int nv, nd, dat;
    bit e;

    initial begin
        rst_n = 1'b0; shift_en = 1'b0; clear = 1'b0; capture = 1'b0;
        src_ser = '0; res_in = '0;
        b_shift_en = 1'b0; b_clear = 1'b0; b_capture = 1'b0; b_src = '0; b_res_in = '0;

        for (int i = 0; i < 32; i++) begin
            tbl[i].sh     = 1'b1;
            tbl[i].b      = (i == 0 || i == 2 || i == 3) ? 1'b1 : 1'b0;
            tbl[i].exp_wv = (i == 31);
        end
        for (int i = 0; i < 10; i++) begin
            btbl[i].src    = 4'($urandom);
            btbl[i].exp_wv = (i >= 7);
        end

        // Reset state
        step(); step();
        check("rst_wv", window_valid, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_res_ser", res_ser, 0);
        check("rst_res_done", res_done, 0);
        check("rst_overrun", overrun, 0);
        check("rst_par_any", |par_out, 0);
        check("rst_b_par", b_par_out, 0);
        check("rst_b_wv", b_wv, 0);
        rst_n = 1'b1;
        step();

        // Fill: 1,0,1,1 then zeros on channel 0
        for (int i = 0; i < 32; i++) begin
            shift_en = tbl[i].sh;
            src_ser  = {31'b0, tbl[i].b};
            step();
            check("fill_wv", window_valid, tbl[i].exp_wv);
        end
        shift_en = 1'b0;
        check("fill_ch0", par_out[31:0], 32'hB000_0000);
        check("fill_others", |par_out[1023:32], 0);

        // Hold when shift_en is low
        src_ser = '1;
        step(); step(); step();
        check("hold_ch0", par_out[31:0], 32'hB000_0000);
        check("hold_wv", window_valid, 1);

        // Clear wins over shift, then saturation
        clear = 1'b1; shift_en = 1'b1;
        step();
        clear = 1'b0;
        check("clear_wv", window_valid, 0);
        check("clear_par", |par_out, 0);
        src_ser = '1;
        for (int i = 0; i < 40; i++) begin
            step();
            check("sat_wv", window_valid, (i >= 31));
        end
        shift_en = 1'b0;
        check("sat_all_ones", &par_out, 1);

        // Serialise 38'h25, capture together with a shift, clear mid-transfer
        res_in = 38'h25; capture = 1'b1; shift_en = 1'b1; src_ser = '0;
        push_a(38'h25);
        step();
        capture = 1'b0; shift_en = 1'b0;
        check("cap_shift_ch0", par_out[31:0], 32'hFFFF_FFFE);
        check("cap_shift_wv", window_valid, 1);
        collect_a(50, 5, -1, nv, nd, dat);
        check("ser_nvalid", nv, 38);
        check("ser_ndone", nd, 1);
        check("ser_done_at", dat, 38);
        check("ser_sb_empty", sb_a.size(), 0);
        check("ser_clear_wv", window_valid, 0);
        check("ser_clear_par", |par_out, 0);
        check("ser_overrun", overrun, 0);

        // Rejected capture with window_valid low
        capture = 1'b1; res_in = 38'h1;
        step();
        capture = 1'b0;
        check("rej_wv0_overrun", overrun, 1);
        collect_a(10, -1, -1, nv, nd, dat);
        check("rej_wv0_nvalid", nv, 0);
        check("rej_wv0_ndone", nd, 0);

        // Reset clears overrun; capture during SEND is rejected
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("rst2_overrun", overrun, 0);
        fill_a(32);
        check("rej_fill_wv", window_valid, 1);
        res_in = 38'h2A5A5; capture = 1'b1;
        push_a(38'h2A5A5);
        step();
        capture = 1'b0;
        collect_a(80, -1, 3, nv, nd, dat);
        check("rej_send_nvalid", nv, 38);
        check("rej_send_ndone", nd, 1);
        check("rej_send_overrun", overrun, 1);
        check("rej_send_sb_empty", sb_a.size(), 0);

        // Reset at the 10th bit of SEND aborts without res_done
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        fill_a(32);
        res_in = 38'h15_5555_5555; capture = 1'b1;
        step();
        capture = 1'b0;
        for (int i = 0; i < 9; i++) step();
        check("abort_valid_before", res_valid, 1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("abort_valid_after", res_valid, 0);
        check("abort_done_after", res_done, 0);
        nd = 0;
        for (int i = 0; i < 6; i++) begin
            if (res_done || res_valid) nd++;
            step();
        end
        check("abort_no_done", nd, 0);
        check("abort_overrun", overrun, 0);

        // Small instance: NCH=4, WIDTH=8, OUTW=5
        m_bpar = '0;
        b_shift_en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            b_src = btbl[i].src;
            for (int k = 0; k < 4; k++) m_bpar[k*8 +: 8] = {m_bpar[k*8 +: 7], btbl[i].src[k]};
            step();
            check("b_fill_wv", b_wv, btbl[i].exp_wv);
            check("b_fill_par", b_par_out, m_bpar);
        end
        b_shift_en = 1'b0;
        b_word = 5'b10110;
        b_res_in = b_word; b_capture = 1'b1;
        for (int i = 0; i < 5; i++) sb_b.push_back(b_word[i]);
        step();
        b_capture = 1'b0;
        nv = 0; nd = 0; dat = -1;
        for (int i = 0; i < 12; i++) begin
            if (b_res_valid) begin
                nv++;
                if (sb_b.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL b_res_ser_unexpected: got valid bit %0b expected no bit", b_res_ser);
                end else begin
                    e = sb_b.pop_front();
                    check("b_res_ser", b_res_ser, e);
                end
            end
            if (b_res_done) begin
                nd++;
                dat = i;
            end
            step();
        end
        check("b_nvalid", nv, 5);
        check("b_ndone", nd, 1);
        check("b_done_at", dat, 5);
        check("b_overrun", b_overrun, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/param_shift_harness.md
PARAM_SHIFT_HARNESS -- requirements
Module: param_shift_harness

Interface
REQ-001 The block SHALL have parameter NCH, default 32, giving the number of serial input channels.
REQ-002 The block SHALL have parameter WIDTH, default 32, giving the depth of each channel shift register in bits (WIDTH >= 2).
REQ-003 The block SHALL have parameter OUTW, default 38, giving the width of the captured result word (OUTW >= 2).
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: synchronous active-low reset.
REQ-006 The block SHALL have port shift_en, input, 1 bit: when high, all channels shift one bit this cycle.
REQ-007 The block SHALL have port clear, input, 1 bit: synchronous zeroing of channel registers and the fill counter.
REQ-008 The block SHALL have port src_ser, input, NCH bits: serial input bit per channel; bit k feeds channel k.
REQ-009 The block SHALL have port par_out, output, NCH*WIDTH bits: channel k register at bits [k*WIDTH +: WIDTH], driven to the downstream datapath.
REQ-010 The block SHALL have port window_valid, output, 1 bit: high when every channel holds WIDTH shifted bits since the last reset or clear.
REQ-011 The block SHALL have port res_in, input, OUTW bits: result word returned by the downstream datapath.
REQ-012 The block SHALL have port capture, input, 1 bit: request to sample res_in and serialise it.
REQ-013 The block SHALL have port res_ser, output, 1 bit: serial result bit, LSB first.
REQ-014 The block SHALL have port res_valid, output, 1 bit: high while res_ser carries a valid bit.
REQ-015 The block SHALL have port res_done, output, 1 bit: one-cycle pulse after the last result bit.
REQ-016 The block SHALL have port overrun, output, 1 bit: sticky flag for a capture that was rejected.

Function
REQ-017 When shift_en=1, each channel register SHALL become {reg[WIDTH-2:0], src_ser[k]}: the new bit enters bit 0 and bit WIDTH-1 is discarded.
REQ-018 When shift_en=0, the channel registers SHALL hold their value.
REQ-019 par_out SHALL be driven directly from the registers, with zero combinational logic.
REQ-020 Fill counter: 0..WIDTH, increments on each shift_en, saturates at WIDTH; window_valid = (count == WIDTH), registered.
REQ-021 clear=1 SHALL zero all channel registers and the fill counter next cycle, regardless of shift_en.
REQ-022 clear SHALL NOT affect the output FSM or overrun.
REQ-023 The output FSM SHALL have exactly two states: IDLE and SEND.
REQ-024 In IDLE, capture=1 with window_valid=1 SHALL load res_in into the output register, set bit index 0, and go to SEND next cycle.
REQ-025 In IDLE, capture=1 with window_valid=0 SHALL be ignored and SHALL set overrun.
REQ-026 In SEND, res_valid=1 and res_ser = outreg[index]; index increments each cycle.
REQ-027 After index reaches OUTW-1, the FSM SHALL return to IDLE, and res_done SHALL pulse in the first IDLE cycle.
REQ-028 A result SHALL take exactly OUTW consecutive res_valid cycles, starting one cycle after the accepted capture.
REQ-029 capture=1 while in SEND SHALL be ignored and SHALL set overrun; the transfer in progress continues unaffected.
REQ-030 capture and shift_en in the same cycle SHALL be legal: res_in is sampled using the pre-shift register contents, and the shift still occurs.
REQ-031 Shifting and clear SHALL continue during SEND, independent of the FSM.
REQ-032 The index counter width SHALL be clog2(OUTW), and the fill counter width SHALL be clog2(WIDTH+1).

Reset
REQ-033 When rst_n=0 at a rising edge, all channel registers, fill counter, output register and index SHALL go to 0, and the FSM SHALL go to IDLE.
REQ-034 After reset, window_valid, res_ser, res_valid, res_done and overrun SHALL all be 0.
REQ-035 Reset SHALL take priority over clear, shift_en and capture.
REQ-036 Reset during SEND SHALL abort the transfer with no res_done pulse.
REQ-037 overrun SHALL be cleared only by reset.

Verification
REQ-038 The bench SHALL cover fill: defaults, shift channel 0 with pattern 1,0,1,1 then 28 zeros -> par_out[31:0]=32'hB0000000; window_valid rises after the 32nd shift, not the 31st.
REQ-039 The bench SHALL cover saturation: 40 shifts of 1 on all channels -> every channel 32'hFFFFFFFF, window_valid stays 1, counter holds 32.
REQ-040 The bench SHALL cover serialise: window_valid=1, res_in=38'h25, capture pulse -> res_valid high 38 cycles, res_ser sequence 1,0,1,0,0,1,0..., then res_done one cycle.
REQ-041 The bench SHALL cover rejected capture: capture during SEND and capture with window_valid=0 -> overrun=1, the first transfer is bit-exact, and no second transfer occurs.
REQ-042 The bench SHALL cover clear/reset: clear mid-fill -> registers 0, window_valid 0; rst_n=0 at the 10th bit of SEND -> res_valid 0 next cycle, no res_done, overrun 0.
REQ-043 The bench SHALL cover parameters: NCH=4, WIDTH=8, OUTW=5 -> window_valid after 8 shifts, 5-cycle transfer, par_out width 32.
